// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row rotation, tick-paced press/release debounce, one-shot key strobe.
// Optional entry-digit shift register enabled by defining KEYPAD_SHIFT_EN.
`timescale 1ns/1ps

module keypad_scan #(
    parameter int cdbits = 16,
    parameter int dbn    = 4
) (
    input  logic       ck,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_vld,
    output logic       key_down,
    output logic [3:0] x3,
    output logic [3:0] x2,
    output logic [3:0] x1,
    output logic [3:0] x0
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] DBN = 4'(dbn);

    state_t            state_q, state_d;
    logic [3:0]        sync1_q, cs_q;
    logic [cdbits-1:0] cnt_q;
    logic [1:0]        ridx_q, ridx_d;
    logic [3:0]        cand_cs_q, cand_cs_d;
    logic [3:0]        cand_code_q, cand_code_d;
    logic [3:0]        mcnt_q, mcnt_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic [3:0]        key_q, key_d;
    logic              vld_q, vld_d;
    logic              down_q, down_d;

    logic              tick;
    logic [3:0]        low_n;
    logic              one_low;
    logic [1:0]        cidx;
    logic [3:0]        mcnt_inc, rcnt_inc;

    function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick     = &cnt_q;
    assign low_n    = ~cs_q;
    assign one_low  = (low_n != 4'd0) && ((low_n & (low_n - 4'd1)) == 4'd0);
    assign mcnt_inc = (mcnt_q == 4'hF) ? 4'hF : mcnt_q + 4'd1;
    assign rcnt_inc = (rcnt_q == 4'hF) ? 4'hF : rcnt_q + 4'd1;

    always_comb begin
        case (low_n)
            4'b0010: cidx = 2'd1;
            4'b0100: cidx = 2'd2;
            4'b1000: cidx = 2'd3;
            default: cidx = 2'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge ck) begin
        if (rst) begin
            sync1_q     <= 4'b1111;
            cs_q        <= 4'b1111;
            cnt_q       <= '0;
            state_q     <= SCAN;
            ridx_q      <= 2'd0;
            cand_cs_q   <= 4'b1111;
            cand_code_q <= 4'd0;
            mcnt_q      <= 4'd0;
            rcnt_q      <= 4'd0;
            key_q       <= 4'd0;
            vld_q       <= 1'b0;
            down_q      <= 1'b0;
        end else begin
            sync1_q     <= col;
            cs_q        <= sync1_q;
            cnt_q       <= cnt_q + cdbits'(1);
            state_q     <= state_d;
            ridx_q      <= ridx_d;
            cand_cs_q   <= cand_cs_d;
            cand_code_q <= cand_code_d;
            mcnt_q      <= mcnt_d;
            rcnt_q      <= rcnt_d;
            key_q       <= key_d;
            vld_q       <= vld_d;
            down_q      <= down_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        ridx_d      = ridx_q;
        cand_cs_d   = cand_cs_q;
        cand_code_d = cand_code_q;
        mcnt_d      = mcnt_q;
        rcnt_d      = rcnt_q;
        key_d       = key_q;
        vld_d       = 1'b0;
        down_d      = down_q;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (one_low) begin
                        cand_cs_d   = cs_q;
                        cand_code_d = code_of(ridx_q, cidx);
                        mcnt_d      = 4'd1;
                        state_d     = DEBOUNCE;
                    end else begin
                        ridx_d = ridx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (cs_q == cand_cs_q) begin
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc >= DBN) begin
                            mcnt_d  = 4'd0;
                            rcnt_d  = 4'd0;
                            key_d   = cand_code_q;
                            down_d  = 1'b1;
                            vld_d   = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        mcnt_d  = 4'd0;
                        ridx_d  = ridx_q + 2'd1;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                // Release is only declared after dbn consecutive all-high samples.
                if (tick) begin
                    if (cs_q == 4'b1111) begin
                        rcnt_d = rcnt_inc;
                        if (rcnt_inc >= DBN) begin
                            rcnt_d  = 4'd0;
                            down_d  = 1'b0;
                            ridx_d  = ridx_q + 2'd1;
                            state_d = SCAN;
                        end
                    end else begin
                        rcnt_d = 4'd0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign row      = ~(4'b0001 << ridx_q);
    assign key      = key_q;
    assign key_vld  = vld_q;
    assign key_down = down_q;

`ifdef KEYPAD_SHIFT_EN
    logic [3:0] x3_q, x2_q, x1_q, x0_q;

    // Shift on the same edge that raises key_vld so the new digit appears with the strobe.
    always_ff @(posedge ck) begin
        if (rst) begin
            x3_q <= 4'd0;
            x2_q <= 4'd0;
            x1_q <= 4'd0;
            x0_q <= 4'd0;
        end else if (vld_d) begin
            x3_q <= x2_q;
            x2_q <= x1_q;
            x1_q <= x0_q;
            x0_q <= cand_code_q;
        end
    end

    assign x3 = x3_q;
    assign x2 = x2_q;
    assign x1 = x1_q;
    assign x0 = x0_q;
`else
    assign x3 = 4'd0;
    assign x2 = 4'd0;
    assign x1 = 4'd0;
    assign x0 = 4'd0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (cdbits=2, dbn=3) with a keypad model and a key scoreboard.
`timescale 1ns/1ps

module tb_keypad_scan;

    logic       ck = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_vld;
    logic       key_down;
    logic [3:0] x3, x2, x1, x0;

    keypad_scan #(.cdbits(2), .dbn(3)) dut (
        .ck       (ck),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .key      (key),
        .key_vld  (key_vld),
        .key_down (key_down),
        .x3       (x3),
        .x2       (x2),
        .x1       (x1),
        .x0       (x0)
    );

    always #5 ck = ~ck;

    // Keypad model: a pressed key pulls its column low only while its row is driven low.
    logic       pressed = 1'b0;
    logic [1:0] kr = 2'd0;
    logic [1:0] kc = 2'd0;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_col = 4'b1111;

    always_comb begin
        col = 4'b1111;
        if (ovr_en)
            col = ovr_col;
        else if (pressed && (row[kr] == 1'b0))
            col = ~(4'b0001 << kc);
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_vld  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_key;
    logic       prev_vld = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every key_vld must match the oldest expected key.
    always @(negedge ck) begin
        if (key_vld === 1'b1) begin
            n_vld++;
            check("key_vld_expected", 16'(exp_q.size() != 0), 16'd1);
            check("key_vld_one_cycle", 16'(prev_vld), 16'd0);
            if (exp_q.size() != 0) begin
                exp_key = exp_q.pop_front();
                check("key_at_vld", 16'(key), 16'(exp_key));
                check("key_down_at_vld", 16'(key_down), 16'd1);
`ifdef KEYPAD_SHIFT_EN
                check("x0_at_vld", 16'(x0), 16'(exp_key));
`else
                check("x0_at_vld", 16'(x0), 16'd0);
`endif
            end
        end
        prev_vld = (key_vld === 1'b1);
    end

    task automatic wait_kd(input logic lvl, input int maxc, input string tag);
        int n = 0;
        while (key_down !== lvl && n < maxc) begin
            @(negedge ck);
            n++;
        end
        check(tag, 16'(key_down), 16'(lvl));
    endtask

    task automatic wait_row(input logic [3:0] tgt, input int maxc, input string tag);
        int n = 0;
        bit other = (row !== tgt);
        while (!(other && row === tgt) && n < maxc) begin
            @(negedge ck);
            n++;
            if (row !== tgt) other = 1'b1;
        end
        check(tag, 16'(row), 16'(tgt));
    endtask

    task automatic press_release(input logic [1:0] r, input logic [1:0] c,
                                 input logic [3:0] code, input string tag);
        exp_q.push_back(code);
        kr = r;
        kc = c;
        pressed = 1'b1;
        wait_kd(1'b1, 100, {tag, "_down"});
        pressed = 1'b0;
        wait_kd(1'b0, 100, {tag, "_release"});
        check({tag, "_key_retained"}, 16'(key), 16'(code));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge ck);
        check("rst_row", 16'(row), 16'h000E);
        check("rst_key", 16'(key), 16'd0);
        check("rst_key_vld", 16'(key_vld), 16'd0);
        check("rst_key_down", 16'(key_down), 16'd0);
        check("rst_x", {x3, x2, x1, x0}, 16'd0);
        rst = 1'b0;

        // Key 5 (row 1, col 1): accepted once, row held while down
        exp_q.push_back(4'h5);
        kr = 2'd1;
        kc = 2'd1;
        pressed = 1'b1;
        wait_kd(1'b1, 100, "k5_down");
        check("k5_row_held", 16'(row), 16'h000D);
        pressed = 1'b0;
        wait_kd(1'b0, 100, "k5_release");
        check("k5_key_retained", 16'(key), 16'h0005);

        // One-tick glitch on row 1101 is dropped and scanning resumes at 1011
        wait_row(4'b1101, 20, "glitch_row_sync");
        ovr_col = 4'b1101;
        ovr_en  = 1'b1;
        repeat (4) @(negedge ck);
        check("glitch_debounce_holds_row", 16'(row), 16'h000D);
        ovr_col = 4'b1111;
        repeat (4) @(negedge ck);
        check("glitch_row_advances", 16'(row), 16'h000B);
        ovr_en = 1'b0;

        // Two columns low: ignored, row keeps rotating
        wait_row(4'b1110, 20, "multi_row_sync");
        ovr_col = 4'b1100;
        ovr_en  = 1'b1;
        wait_row(4'b1101, 8, "multi_rot_1101");
        wait_row(4'b1011, 8, "multi_rot_1011");
        wait_row(4'b0111, 8, "multi_rot_0111");
        wait_row(4'b1110, 8, "multi_rot_1110");
        ovr_en = 1'b0;

        // Entry sequence 1,2,3,A
        press_release(2'd0, 2'd0, 4'h1, "k1");
        press_release(2'd0, 2'd1, 4'h2, "k2");
        press_release(2'd0, 2'd2, 4'h3, "k3");
        press_release(2'd0, 2'd3, 4'hA, "kA");
`ifdef KEYPAD_SHIFT_EN
        check("entry_digits", {x3, x2, x1, x0}, 16'h123A);
`else
        check("entry_digits", {x3, x2, x1, x0}, 16'h0000);
`endif

        // Long hold, then reset abandons the key and it is re-accepted
        exp_q.push_back(4'h3);
        kr = 2'd0;
        kc = 2'd2;
        pressed = 1'b1;
        wait_kd(1'b1, 100, "hold_down");
        repeat (160) @(negedge ck);
        check("hold_still_down", 16'(key_down), 16'd1);
        rst = 1'b1;
        @(negedge ck);
        check("hold_rst_row", 16'(row), 16'h000E);
        check("hold_rst_key", 16'(key), 16'd0);
        check("hold_rst_key_vld", 16'(key_vld), 16'd0);
        check("hold_rst_key_down", 16'(key_down), 16'd0);
        check("hold_rst_x", {x3, x2, x1, x0}, 16'd0);
        exp_q.push_back(4'h3);
        rst = 1'b0;
        cyc = 0;
        while (key_vld !== 1'b1 && cyc < 40) begin
            @(negedge ck);
            cyc++;
        end
        check("reaccept_latency", 16'(cyc), 16'd12);
        pressed = 1'b0;
        wait_kd(1'b0, 100, "reaccept_release");

        repeat (4) @(negedge ck);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        check("key_vld_total", 16'(n_vld), 16'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
